rxparity: RTL and testbench
===========================

# rxparity

Serial receive deframer and parity checker for the USRT link; the receive-side counterpart of the transmit parity/framing generator. It samples the line on `i_Pclk` qualified by a bit strobe, recognises 11-bit frames {start, D7..D0, parity, stop}, recovers the data byte and checks parity and stop bit. It presents the byte with a one-cycle valid pulse and error flags to the downstream receive logic.

## Interface
Parameters: none.

Ports:
- i_Pclk  input  1  clock; all logic on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_En  input  1  bit strobe; `i_Rx` is sampled only on edges where `i_En`=1
- i_Rx  input  1  serial line, idles high
- i_Parity  input  2  parity mode: 01 even, 10 odd, 00/11 none
- o_Data  output  8  received byte, held until next frame completes
- o_Valid  output  1  one-cycle pulse: frame complete, `o_Data` and error flags updated
- o_ParityErr  output  1  parity mismatch on last frame, held
- o_FrameErr  output  1  stop bit sampled 0 on last frame, held
- o_ErrCnt  output  8  saturating error-frame count (see Configuration)

## Operation
- Frame on the wire, MSB first: start(0), D7, D6 … D0, parity, stop(1); always 11 bits, parity slot present in every mode.
- FSM states and transitions; all transitions occur only on strobed edges (`i_En`=1):
  - IDLE: `i_Rx`=0 → START_SEEN. Latch `i_Parity` into the frame mode, clear the bit counter and running XOR.
  - DATA: shift `i_Rx` into the shift register MSB-first and XOR it into the running parity. After 8 samples → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: sample the stop bit and update outputs (below). Stop=1 → IDLE; stop=0 → WAIT.
  - WAIT: stay until `i_Rx`=1 is sampled → IDLE. A line held low is never taken as a new start bit.
- START_SEEN is the DATA entry: the first strobed sample after the start bit is D7.
- Expected parity bit:
  - even: XOR(D7..D0)
  - odd: ~XOR(D7..D0)
  - none: parity slot ignored, `o_ParityErr` forced 0
- Output update on the STOP edge:
  - `o_Data` ← shift register
  - `o_ParityErr` ← mismatch
  - `o_FrameErr` ← ~stop
  - `o_Valid` ← 1
- Data is delivered even on error; flags describe that frame only.
- `i_Parity` changes mid-frame are ignored; the latched mode applies until the next start bit.
- Cycles with `i_En`=0 freeze the FSM, counter and shift register.

## Timing
- Reset values: state IDLE; `o_Data`=8'h00; `o_Valid`=0; `o_ParityErr`=0; `o_FrameErr`=0; `o_ErrCnt`=0.
- All outputs are registered.
- `o_Valid` is high exactly the one `i_Pclk` cycle after the edge that samples the stop bit, regardless of `i_En` in that cycle.
- Minimum frame: 11 strobed edges from the start-bit sample to the stop-bit sample.
- Back-to-back frames: a start bit may be sampled on the strobed edge immediately after the stop edge. That is the same cycle `o_Valid` is high; both are handled.
- Reset mid-frame:
  - takes effect on the next edge and aborts the frame
  - no `o_Valid` pulse
  - flags and counter cleared
  - `i_Rst` overrides `i_En`

## Configuration
- Macro `RXPARITY_ERRCNT_EN`.
- Defined:
  - `o_ErrCnt` increments by 1 on each `o_Valid` frame with `o_ParityErr` or `o_FrameErr` set; a frame with both flags counts once.
  - Saturates at 8'hFF and clears only on reset.
- Undefined:
  - counter logic is not built
  - `o_ErrCnt` is tied to 8'h00
  - all other behaviour is identical

## Test plan
- Even mode, `i_En`=1 constant, byte 0xA5 (line 0,1,0,1,0,0,1,0,1,0,1) → one-cycle `o_Valid`, `o_Data`=0xA5, `o_ParityErr`=0, `o_FrameErr`=0.
- Odd mode, byte 0x01 with parity bit 1 (expected 0) → `o_Data`=0x01, `o_ParityErr`=1; `o_ErrCnt`=1 with the macro defined, 0 without.
- Byte 0x3C with stop bit 0, then line held 0 for 5 strobes, then 1, then a valid 0x5A frame:
  - first frame: `o_FrameErr`=1
  - no frame decoded while the line is low
  - 0x5A frame: `o_Valid`, `o_Data`=0x5A, `o_FrameErr`=0
- `i_En` asserted every 3rd cycle, 0xC3 even mode → identical result; `o_Valid` appears one cycle after the 11th strobed edge.
- Reset asserted after 5 data bits of a frame, then a full 0x81 frame:
  - no `o_Valid` for the aborted frame
  - all outputs at reset values
  - the 0x81 frame decodes correctly
- With `RXPARITY_ERRCNT_EN` defined, 300 back-to-back parity-error frames → `o_ErrCnt` stops at 8'hFF.

Source files
------------

// File: rtl/rxparity.sv
// ---------------------------------------------------------------------------
// rxparity -- USRT serial receive deframer and parity checker.
//
// Recognises 11-bit frames {start(0), D7..D0, parity, stop(1)}, MSB first,
// sampled on i_Pclk edges qualified by the bit strobe i_En. Recovers the data
// byte, checks parity (even/odd/none) and the stop bit, and presents the byte
// with a one-cycle valid pulse and held error flags.
//
// Ports:
//   i_Pclk       clock, rising edge
//   i_Rst        synchronous active-high reset (overrides i_En)
//   i_En         bit strobe; i_Rx sampled only when high
//   i_Rx         serial line, idles high
//   i_Parity     parity mode: 01 even, 10 odd, 00/11 none (latched at start)
//   o_Data       received byte, held until next frame completes
//   o_Valid      one-cycle pulse after the stop-bit sample
//   o_ParityErr  parity mismatch on last frame, held
//   o_FrameErr   stop bit sampled low on last frame, held
//   o_ErrCnt     saturating count of errored frames
//
// Configuration macro: RXPARITY_ERRCNT_EN
//   defined   -> o_ErrCnt counts frames with either error flag, saturating
//                at 8'hFF, cleared only by reset
//   undefined -> counter not built, o_ErrCnt tied to 8'h00
// ---------------------------------------------------------------------------
module rxparity (
    input  logic       i_Pclk,
    input  logic       i_Rst,
    input  logic       i_En,
    input  logic       i_Rx,
    input  logic [1:0] i_Parity,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_ParityErr,
    output logic       o_FrameErr,
    output logic [7:0] o_ErrCnt
);

    localparam logic [1:0] MODE_EVEN = 2'b01;
    localparam logic [1:0] MODE_ODD  = 2'b10;

    // The start-bit sample moves IDLE straight into DATA, so DATA doubles as
    // the "start seen" state: the next strobed sample is D7.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_acc;
    logic       par_bit;
    logic [1:0] mode;
    logic       par_mismatch;

    function automatic logic parity_mismatch(input logic [1:0] m,
                                             input logic       acc,
                                             input logic       pb);
        case (m)
            MODE_EVEN: return pb != acc;
            MODE_ODD:  return pb == acc;   // odd expects ~acc
            default:   return 1'b0;        // no parity: slot ignored
        endcase
    endfunction

    assign par_mismatch = parity_mismatch(mode, par_acc, par_bit);

    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            par_acc     <= 1'b0;
            par_bit     <= 1'b0;
            mode        <= 2'b00;
            o_Data      <= 8'h00;
            o_Valid     <= 1'b0;
            o_ParityErr <= 1'b0;
            o_FrameErr  <= 1'b0;
        end else begin
            // Valid is a pulse independent of the strobe in the following cycle.
            o_Valid <= 1'b0;
            if (i_En) begin
                case (state)
                    S_IDLE: begin
                        if (!i_Rx) begin
                            mode    <= i_Parity;
                            bit_cnt <= 3'd0;
                            par_acc <= 1'b0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {shreg[6:0], i_Rx};
                        par_acc <= par_acc ^ i_Rx;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= i_Rx;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        o_Data      <= shreg;
                        o_ParityErr <= par_mismatch;
                        o_FrameErr  <= ~i_Rx;
                        o_Valid     <= 1'b1;
                        // A low stop bit means the line may still be low; wait
                        // for it to return high so it is not taken as a start.
                        state       <= i_Rx ? S_IDLE : S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_Rx) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef RXPARITY_ERRCNT_EN
    logic [7:0] err_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Counts on the stop edge so the count updates together with o_Valid;
    // a frame with both errors counts once.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            err_cnt <= 8'h00;
        end else if (i_En && (state == S_STOP) && (par_mismatch || !i_Rx)) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    assign o_ErrCnt = err_cnt;
`else
    assign o_ErrCnt = 8'h00;
`endif

endmodule

// File: tb/tb_rxparity.sv
module tb_rxparity;

    logic       i_Pclk = 1'b0;
    logic       i_Rst;
    logic       i_En;
    logic       i_Rx;
    logic [1:0] i_Parity;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_ParityErr;
    logic       o_FrameErr;
    logic [7:0] o_ErrCnt;

    rxparity dut (
        .i_Pclk      (i_Pclk),
        .i_Rst       (i_Rst),
        .i_En        (i_En),
        .i_Rx        (i_Rx),
        .i_Parity    (i_Parity),
        .o_Data      (o_Data),
        .o_Valid     (o_Valid),
        .o_ParityErr (o_ParityErr),
        .o_FrameErr  (o_FrameErr),
        .o_ErrCnt    (o_ErrCnt)
    );

    always #5 i_Pclk = ~i_Pclk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] ec;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_cnt = 8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse pops one expected frame.
    always @(negedge i_Pclk) begin
        if (o_Valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got frame data %02h, expected no frame at %0t",
                         o_Data, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("data", o_Data, mon_e.d);
                chk("parity_err", {7'd0, o_ParityErr}, {7'd0, mon_e.pe});
                chk("frame_err", {7'd0, o_FrameErr}, {7'd0, mon_e.fe});
                chk("err_cnt", o_ErrCnt, mon_e.ec);
            end
        end
    end

    // One line bit lasting per cycles, strobed on the last cycle.
    task automatic strobe_bit(input logic b, input int per);
        i_Rx = b;
        for (int k = 0; k < per; k++) begin
            i_En = (k == per - 1);
            @(posedge i_Pclk);
            #1;
        end
        i_En = 1'b0;
    endtask

    task automatic idle(input int n);
        i_Rx = 1'b1;
        i_En = 1'b1;
        repeat (n) begin
            @(posedge i_Pclk);
            #1;
        end
        i_En = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic [1:0] mode, input int per,
                              input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
`ifdef RXPARITY_ERRCNT_EN
        if (pe || fe) model_cnt = (model_cnt == 8'hFF) ? 8'hFF : model_cnt + 8'd1;
`endif
        e.ec = model_cnt;
        sb.push_back(e);
        i_Parity = mode;
        strobe_bit(1'b0, per);
        // Mode change after the start bit must not affect this frame.
        i_Parity = mode ^ 2'b11;
        for (int i = 7; i >= 0; i--) strobe_bit(d[i], per);
        strobe_bit(p, per);
        strobe_bit(s, per);
        chk("valid_latency", {7'd0, o_Valid}, 8'h01);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_data"}, o_Data, 8'h00);
        chk({tag, "_valid"}, {7'd0, o_Valid}, 8'h00);
        chk({tag, "_parity_err"}, {7'd0, o_ParityErr}, 8'h00);
        chk({tag, "_frame_err"}, {7'd0, o_FrameErr}, 8'h00);
        chk({tag, "_err_cnt"}, o_ErrCnt, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Rst    = 1'b1;
        i_En     = 1'b0;
        i_Rx     = 1'b1;
        i_Parity = 2'b01;
        repeat (2) @(posedge i_Pclk);
        #1;
        chk_reset_values("reset");
        i_Rst = 1'b0;
        idle(3);

        // Even 0xA5: four ones, parity 0.
        send_frame(8'hA5, 1'b0, 1'b1, 2'b01, 1, 1'b0, 1'b0);
        idle(2);
        // Odd 0x01: expected parity 0, sent 1.
        send_frame(8'h01, 1'b1, 1'b1, 2'b10, 1, 1'b1, 1'b0);
        idle(2);
        // No parity: 0x7F with a parity slot that would be wrong for even.
        send_frame(8'h7F, 1'b0, 1'b1, 2'b00, 1, 1'b0, 1'b0);
        idle(2);

        // Reset after start + 5 data bits, with i_En low (reset overrides).
        i_Parity = 2'b01;
        strobe_bit(1'b0, 1);
        for (int i = 0; i < 5; i++) strobe_bit(1'b1, 1);
        i_Rst = 1'b1;
        i_Rx  = 1'b1;
        @(posedge i_Pclk);
        #1;
        i_Rst     = 1'b0;
        model_cnt = 8'h00;
        chk_reset_values("midframe_reset");
        idle(2);
        // Odd 0x81: two ones, expected parity 1.
        send_frame(8'h81, 1'b1, 1'b1, 2'b10, 1, 1'b0, 1'b0);
        idle(2);

        // 0x3C with a low stop bit, line held low, then recovery with 0x5A.
        send_frame(8'h3C, 1'b0, 1'b0, 2'b01, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) strobe_bit(1'b0, 1);
        strobe_bit(1'b1, 1);
        idle(2);
        send_frame(8'h5A, 1'b0, 1'b1, 2'b01, 1, 1'b0, 1'b0);
        idle(2);

        // Strobe every 3rd cycle, even 0xC3.
        send_frame(8'hC3, 1'b0, 1'b1, 2'b01, 3, 1'b0, 1'b0);
        idle(2);

        // Back-to-back frames: next start bit on the edge after the stop.
        send_frame(8'hA5, 1'b0, 1'b1, 2'b01, 1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 2'b01, 1, 1'b1, 1'b0);
        idle(2);

`ifdef RXPARITY_ERRCNT_EN
        // 300 back-to-back parity-error frames: counter saturates.
        for (int n = 0; n < 300; n++) send_frame(8'h00, 1'b1, 1'b1, 2'b01, 1, 1'b1, 1'b0);
        idle(2);
        chk("err_cnt_saturated", o_ErrCnt, 8'hFF);
`endif

        idle(3);
        chk("pending_frames", 8'(sb.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
